// File: rtl/divisor_shift_sub_8_bits.sv
// Sequential restoring (shift-subtract) unsigned divider.
// One quotient bit is resolved per clock, MSB first, behind a
// start/busy/done handshake. A zero divisor is flagged immediately
// instead of being iterated.
module divisor_shift_sub_8_bits #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH:0]   r_reg, r_next;
    logic [WIDTH-1:0] d_reg, d_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [WIDTH-1:0] quotient_reg, quotient_next;
    logic [WIDTH-1:0] remainder_reg, remainder_next;
    logic             done_reg, done_next;
    logic             div_zero_reg, div_zero_next;

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the subtraction only if it did not borrow.
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   step_r;
    logic [WIDTH-1:0] step_q;

    // Datapath for a single iteration of the shift-subtract loop
    always_comb begin
        shifted = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        trial   = shifted - {1'b0, d_reg};
        if (!trial[WIDTH]) begin
            step_r = trial;
            step_q = {q_reg[WIDTH-2:0], 1'b1};
        end else begin
            step_r = shifted;
            step_q = {q_reg[WIDTH-2:0], 1'b0};
        end
    end

    // Next-state and next-output logic; results only move at completion
    always_comb begin
        state_next     = state_reg;
        q_next         = q_reg;
        r_next         = r_reg;
        d_next         = d_reg;
        cnt_next       = cnt_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        div_zero_next  = div_zero_reg;
        done_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        d_next     = divisor;
                        q_next     = dividend;
                        r_next     = '0;
                        cnt_next   = '0;
                        state_next = CALC;
                    end else begin
                        // Zero divisor: answer at once without iterating
                        done_next      = 1'b1;
                        div_zero_next  = 1'b1;
                        quotient_next  = '1;
                        remainder_next = dividend;
                    end
                end
            end
            CALC: begin
                q_next   = step_q;
                r_next   = step_r;
                cnt_next = cnt_reg + CNT_W'(1);
                if (cnt_reg == LAST_STEP) begin
                    quotient_next  = step_q;
                    remainder_next = step_r[WIDTH-1:0];
                    div_zero_next  = 1'b0;
                    done_next      = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and result registers; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            q_reg         <= '0;
            r_reg         <= '0;
            d_reg         <= '0;
            cnt_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            done_reg      <= 1'b0;
            div_zero_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            q_reg         <= q_next;
            r_reg         <= r_next;
            d_reg         <= d_next;
            cnt_reg       <= cnt_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            done_reg      <= done_next;
            div_zero_reg  <= div_zero_next;
        end
    end

    assign busy      = (state_reg == CALC);
    assign done      = done_reg;
    assign div_zero  = div_zero_reg;
    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;

endmodule

// File: tb/tb_divisor_shift_sub_8_bits.sv
// Bench for the shift-subtract divider: directed cases followed by a
// randomized regression against plain integer division.
module tb_divisor_shift_sub_8_bits;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_zero;

    int errors = 0;
    int checks = 0;

    divisor_shift_sub_8_bits #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one request at the current falling edge and follow it to done.
    // With junk set, start is re-asserted with other operands while busy.
    // Returns at the falling edge where done is observed.
    task automatic do_op(input int a, input int b, input bit junk, input int ja, input int jb);
        int cycles;
        int exp_q, exp_r, exp_z, exp_lat;
        if (b == 0) begin
            exp_q   = (1 << WIDTH) - 1;
            exp_r   = a;
            exp_z   = 1;
            exp_lat = 1;
        end else begin
            exp_q   = a / b;
            exp_r   = a % b;
            exp_z   = 0;
            exp_lat = WIDTH + 1;
        end
        dividend = WIDTH'(a);
        divisor  = WIDTH'(b);
        start    = 1'b1;
        @(negedge clk);
        cycles   = 1;
        start    = 1'b0;
        dividend = WIDTH'($urandom);
        divisor  = WIDTH'($urandom);
        while (done !== 1'b1 && cycles < 40) begin
            check("busy_during_calc", {31'd0, busy}, 32'd1);
            check("done_low_while_busy", {31'd0, done}, 32'd0);
            if (junk) begin
                start    = 1'b1;
                dividend = WIDTH'(ja);
                divisor  = WIDTH'(jb);
            end
            @(negedge clk);
            cycles++;
            start = 1'b0;
        end
        check("latency", cycles, exp_lat);
        check("done_pulse", {31'd0, done}, 32'd1);
        check("busy_with_done", {31'd0, busy}, 32'd0);
        check("quotient", {24'd0, quotient}, exp_q);
        check("remainder", {24'd0, remainder}, exp_r);
        check("div_zero", {31'd0, div_zero}, exp_z);
        if (b != 0) begin
            check("invariant", int'(quotient) * b + int'(remainder), a);
            check("rem_lt_div", {31'd0, (int'(remainder) < b)}, 32'd1);
        end
        $display("op %0d/%0d -> q=%0d r=%0d z=%0d lat=%0d", a, b, quotient, remainder, div_zero, cycles);
    endtask

    // One falling edge later done must be gone (one-cycle pulse)
    task automatic idle_check();
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_quotient", {24'd0, quotient}, 32'd0);
        check("rst_remainder", {24'd0, remainder}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_div_zero", {31'd0, div_zero}, 32'd0);

        // Directed cases
        do_op(100, 7, 1'b0, 0, 0);   idle_check();
        do_op(255, 1, 1'b0, 0, 0);   idle_check();
        do_op(255, 255, 1'b0, 0, 0); idle_check();
        do_op(5, 10, 1'b0, 0, 0);    idle_check();
        do_op(0, 3, 1'b0, 0, 0);     idle_check();
        do_op(200, 0, 1'b0, 0, 0);   idle_check();

        // Start while busy is ignored; then a start in the done cycle is taken
        do_op(100, 7, 1'b1, 9, 3);
        do_op(9, 3, 1'b0, 0, 0);
        idle_check();

        // Reset in the middle of an operation
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_quotient", {24'd0, quotient}, 32'd0);
        check("abort_remainder", {24'd0, remainder}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_div_zero", {31'd0, div_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("no_done_after_abort", {31'd0, done}, 32'd0);
        end
        do_op(50, 6, 1'b0, 0, 0);
        idle_check();

        // Randomized regression
        for (int i = 0; i < 1000; i++) begin
            int a, b;
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            do_op(a, b, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) idle_check();
        end
        idle_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
